// File: rtl/write_back_stage_pkg.sv
// Shared pipeline encodings used by the write-back stage and its neighbours.
package write_back_stage_pkg;

  // Write-back source select encodings
  localparam logic [3:0] WB_X   = 4'd0;
  localparam logic [3:0] WB_ALU = 4'd1;
  localparam logic [3:0] WB_MEM = 4'd2;
  localparam logic [3:0] WB_PC  = 4'd3;

  // Register-read enable "don't care"
  localparam logic REN_X = 1'b0;

  // Bubble markers injected by upstream stages
  localparam logic [63:0] INST_ID_NOP = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [31:0] REGPC_NOP   = 32'h0000_0000;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_FLUSH = 1'b1
  } flush_state_e;

  // True for the select values that actually produce a register write
  function automatic logic wb_sel_writes(input logic [3:0] sel);
    return (sel == WB_ALU) || (sel == WB_MEM) || (sel == WB_PC);
  endfunction

endpackage

// File: rtl/write_back_stage_flush_ctrl.sv
// Redirect flush controller: holds the squash window open after a redirect
// and keeps the redirect target stable for its duration.
//
// state    | meaning
// ---------+------------------------------------------------------------
// FL_IDLE  | no flush in progress, flush_cnt == 0
// FL_FLUSH | younger slots squashed, flush_cnt counts down to 0
module wb_flush_ctrl
  import write_back_stage_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES    = 2,
  parameter logic [31:0] RESET_PC_TARGET = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_i,
  input  logic [31:0] br_target_i,
  output logic        flush_active_o,
  output logic        hazard_o,
  output logic [31:0] target_o
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  flush_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [31:0]  target_q, target_d;

  // State, counter and target registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FL_IDLE;
      cnt_q    <= 3'd0;
      target_q <= RESET_PC_TARGET;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
    end
  end

  // Next-state: load the countdown on a redirect, count to zero while flushing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    unique case (state_q)
      FL_IDLE: begin
        if (redirect_i) begin
          target_d = br_target_i;
          cnt_d    = CNT_LOAD;
          if (CNT_LOAD != 3'd0) state_d = FL_FLUSH;
        end
      end
      FL_FLUSH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = FL_IDLE;
      end
      default: begin
        state_d = FL_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  assign flush_active_o = (cnt_q != 3'd0);
  assign hazard_o       = redirect_i || flush_active_o;
  assign target_o       = redirect_i     ? br_target_i :
                          flush_active_o ? target_q    : RESET_PC_TARGET;

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: register write-back, forwarding, redirect and retire.
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES    = 2,
  parameter logic [31:0] RESET_PC_TARGET = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] input_reg_pc,
  input  logic [31:0] input_inst,
  input  logic [63:0] input_inst_id,
  input  logic [31:0] input_read_data,
  input  logic [31:0] input_alu_out,
  input  logic        input_br_flg,
  input  logic [31:0] input_br_target,
  input  logic        input_rf_wen,
  input  logic [3:0]  input_wb_sel,
  input  logic [4:0]  input_wb_addr,
  input  logic        input_jmp_flg,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fw_valid,
  output logic [4:0]  fw_addr,
  output logic [31:0] fw_data,
  output logic        wb_branch_hazard,
  output logic [31:0] wb_branch_target,
  output logic        retire_valid,
  output logic [31:0] retire_pc,
  output logic [63:0] retire_inst_id,
  output logic [63:0] instret
);

  logic        flush_active;
  logic        bubble;
  logic        redirect;
  logic [31:0] wb_val;

  logic        fw_valid_q;
  logic [4:0]  fw_addr_q;
  logic [31:0] fw_data_q;
  logic        retire_valid_q;
  logic [31:0] retire_pc_q;
  logic [63:0] retire_inst_id_q;
  logic [63:0] instret_q;

  // The instruction word is carried for trace only; nothing here decodes it
  logic unused_inst;
  assign unused_inst = ^input_inst;

  // Reset is folded into the bubble so combinational outputs stay quiet in reset
  assign bubble   = !rst_n || (input_inst_id == INST_ID_NOP) || flush_active;
  assign redirect = !bubble && (input_br_flg || input_jmp_flg);

  // Write-back value select
  always_comb begin
    wb_val = 32'h0;
    unique case (input_wb_sel)
      WB_ALU:  wb_val = input_alu_out;
      WB_MEM:  wb_val = input_read_data;
      WB_PC:   wb_val = input_reg_pc + 32'd4;
      default: wb_val = 32'h0;
    endcase
  end

  assign rf_we    = !bubble && input_rf_wen && wb_sel_writes(input_wb_sel)
                    && (input_wb_addr != 5'd0);
  assign rf_waddr = input_wb_addr;
  assign rf_wdata = wb_val;

  // Forwarding copy of the register write, covering the RF write-before-read gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fw_valid_q <= 1'b0;
      fw_addr_q  <= 5'd0;
      fw_data_q  <= 32'h0;
    end else begin
      fw_valid_q <= rf_we;
      fw_addr_q  <= rf_waddr;
      fw_data_q  <= rf_wdata;
    end
  end

  // Retire trace and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_valid_q   <= 1'b0;
      retire_pc_q      <= 32'h0;
      retire_inst_id_q <= INST_ID_NOP;
      instret_q        <= 64'd0;
    end else begin
      retire_valid_q <= !bubble;
      if (!bubble) begin
        retire_pc_q      <= input_reg_pc;
        retire_inst_id_q <= input_inst_id;
        instret_q        <= instret_q + 64'd1;
      end
    end
  end

  wb_flush_ctrl #(
    .FLUSH_CYCLES    (FLUSH_CYCLES),
    .RESET_PC_TARGET (RESET_PC_TARGET)
  ) u_flush_ctrl (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_i     (redirect),
    .br_target_i    (input_br_target),
    .flush_active_o (flush_active),
    .hazard_o       (wb_branch_hazard),
    .target_o       (wb_branch_target)
  );

  assign fw_valid       = fw_valid_q;
  assign fw_addr        = fw_addr_q;
  assign fw_data        = fw_data_q;
  assign retire_valid   = retire_valid_q;
  assign retire_pc      = retire_pc_q;
  assign retire_inst_id = retire_inst_id_q;
  assign instret        = instret_q;

endmodule
